// File: rtl/control_fsm.sv
// Multicycle LC-3b control unit for the mp0 datapath.
// Moore FSM: next state is registered, control outputs decode from state.
module control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       branch_enable,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_cc,
    output logic       pcmux_sel,
    output logic       storemux_sel,
    output logic       alumux_sel,
    output logic       regfilemux_sel,
    output logic       marmux_sel,
    output logic       mdrmux_sel,
    output logic [2:0] aluop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_byte_enable
);

    localparam logic [3:0] OP_BR  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h9;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_AND  = 3'd1;
    localparam logic [2:0] ALU_NOT  = 3'd2;
    localparam logic [2:0] ALU_PASS = 3'd3;

    typedef enum logic [3:0] {
        FETCH1    = 4'd0,
        FETCH2    = 4'd1,
        FETCH3    = 4'd2,
        DECODE    = 4'd3,
        S_ADD     = 4'd4,
        S_AND     = 4'd5,
        S_NOT     = 4'd6,
        BR        = 4'd7,
        BR_TAKEN  = 4'd8,
        CALC_ADDR = 4'd9,
        LDR1      = 4'd10,
        LDR2      = 4'd11,
        STR1      = 4'd12,
        STR2      = 4'd13
    } state_t;

    state_t state;

    // State register; unencoded values fall back to FETCH1
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH1;
        end else begin
            case (state)
                FETCH1:    state <= FETCH2;
                FETCH2:    state <= mem_resp ? FETCH3 : FETCH2;
                FETCH3:    state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_ADD:  state <= S_ADD;
                        OP_AND:  state <= S_AND;
                        OP_NOT:  state <= S_NOT;
                        OP_BR:   state <= BR;
                        OP_LDR:  state <= CALC_ADDR;
                        OP_STR:  state <= CALC_ADDR;
                        default: state <= FETCH1;
                    endcase
                end
                S_ADD:     state <= FETCH1;
                S_AND:     state <= FETCH1;
                S_NOT:     state <= FETCH1;
                BR:        state <= branch_enable ? BR_TAKEN : FETCH1;
                BR_TAKEN:  state <= FETCH1;
                CALC_ADDR: begin
                    case (opcode)
                        OP_LDR:  state <= LDR1;
                        OP_STR:  state <= STR1;
                        default: state <= FETCH1;
                    endcase
                end
                LDR1:      state <= mem_resp ? LDR2 : LDR1;
                LDR2:      state <= FETCH1;
                STR1:      state <= STR2;
                STR2:      state <= mem_resp ? FETCH1 : STR2;
                default:   state <= FETCH1;
            endcase
        end
    end

    // Control decode; reset forces every control to its idle value
    always_comb begin
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_cc         = 1'b0;
        pcmux_sel       = 1'b0;
        storemux_sel    = 1'b0;
        alumux_sel      = 1'b0;
        regfilemux_sel  = 1'b0;
        marmux_sel      = 1'b0;
        mdrmux_sel      = 1'b0;
        aluop           = ALU_ADD;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b11;
        if (!reset) begin
            case (state)
                FETCH1: begin
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                    load_pc    = 1'b1;
                end
                FETCH2: begin
                    mdrmux_sel = 1'b1;
                    load_mdr   = 1'b1;
                    mem_read   = 1'b1;
                end
                FETCH3: load_ir = 1'b1;
                S_ADD: begin
                    aluop        = ALU_ADD;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                end
                S_AND: begin
                    aluop        = ALU_AND;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                end
                S_NOT: begin
                    aluop        = ALU_NOT;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                end
                BR_TAKEN: begin
                    pcmux_sel = 1'b1;
                    load_pc   = 1'b1;
                end
                CALC_ADDR: begin
                    alumux_sel = 1'b1;
                    aluop      = ALU_ADD;
                    load_mar   = 1'b1;
                end
                LDR1: begin
                    mdrmux_sel = 1'b1;
                    load_mdr   = 1'b1;
                    mem_read   = 1'b1;
                end
                LDR2: begin
                    regfilemux_sel = 1'b1;
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                end
                STR1: begin
                    storemux_sel = 1'b1;
                    aluop        = ALU_PASS;
                    load_mdr     = 1'b1;
                end
                STR2: mem_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: instruction-level stimulus expands into an
// expected per-cycle control trace that a compare process checks.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       branch_enable = 1'b0;
    logic       mem_resp = 1'b0;
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
    logic       pcmux_sel, storemux_sel, alumux_sel;
    logic       regfilemux_sel, marmux_sel, mdrmux_sel;
    logic [2:0] aluop;
    logic       mem_read, mem_write;
    logic [1:0] mem_byte_enable;

    control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .branch_enable(branch_enable), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_ir(load_ir),
        .load_regfile(load_regfile), .load_mar(load_mar),
        .load_mdr(load_mdr), .load_cc(load_cc),
        .pcmux_sel(pcmux_sel), .storemux_sel(storemux_sel),
        .alumux_sel(alumux_sel), .regfilemux_sel(regfilemux_sel),
        .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel),
        .aluop(aluop), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] OP_BR  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h9;

    // Bit positions of the packed control word
    localparam logic [19:0] M_PC    = 20'h1 << 19;
    localparam logic [19:0] M_IR    = 20'h1 << 18;
    localparam logic [19:0] M_RF    = 20'h1 << 17;
    localparam logic [19:0] M_MAR   = 20'h1 << 16;
    localparam logic [19:0] M_MDR   = 20'h1 << 15;
    localparam logic [19:0] M_CC    = 20'h1 << 14;
    localparam logic [19:0] M_PCMX  = 20'h1 << 13;
    localparam logic [19:0] M_STMX  = 20'h1 << 12;
    localparam logic [19:0] M_ALUMX = 20'h1 << 11;
    localparam logic [19:0] M_RFMX  = 20'h1 << 10;
    localparam logic [19:0] M_MARMX = 20'h1 << 9;
    localparam logic [19:0] M_MDRMX = 20'h1 << 8;
    localparam logic [19:0] A_AND   = 20'd1 << 5;
    localparam logic [19:0] A_NOT   = 20'd2 << 5;
    localparam logic [19:0] A_PASS  = 20'd3 << 5;
    localparam logic [19:0] M_RD    = 20'h1 << 4;
    localparam logic [19:0] M_WR    = 20'h1 << 3;
    localparam logic [19:0] DEF     = 20'h3;

    localparam logic [19:0] V_F1   = DEF | M_MAR | M_MARMX | M_PC;
    localparam logic [19:0] V_RD   = DEF | M_MDRMX | M_MDR | M_RD;
    localparam logic [19:0] V_F3   = DEF | M_IR;
    localparam logic [19:0] V_ALU  = DEF | M_RF | M_CC;
    localparam logic [19:0] V_BRT  = DEF | M_PCMX | M_PC;
    localparam logic [19:0] V_CALC = DEF | M_ALUMX | M_MAR;
    localparam logic [19:0] V_LDR2 = DEF | M_RFMX | M_RF | M_CC;
    localparam logic [19:0] V_STR1 = DEF | M_STMX | A_PASS | M_MDR;
    localparam logic [19:0] V_STR2 = DEF | M_WR;

    logic [19:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int budget = 1000000;
    int since = 0, rd_since = 0, wr_since = 0;
    int last_len = 0, rd_last = 0, wr_last = 0;

    wire [19:0] act = {load_pc, load_ir, load_regfile, load_mar,
                       load_mdr, load_cc, pcmux_sel, storemux_sel,
                       alumux_sel, regfilemux_sel, marmux_sel,
                       mdrmux_sel, aluop, mem_read, mem_write,
                       1'b0, mem_byte_enable};

    // Compare DUT controls against the expected trace every cycle
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL controls t=%0t got %h exp %h",
                             $time, act, e);
                end
                if (act[16] && act[9]) begin
                    last_len = since;
                    rd_last  = rd_since;
                    wr_last  = wr_since;
                    since    = 0;
                    rd_since = 0;
                    wr_since = 0;
                end
                since++;
                rd_since += int'(act[4]);
                wr_since += int'(act[3]);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, want);
        end
    endtask

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic cyc(input logic [19:0] e, input logic [3:0] op,
                       input logic resp, input logic ben,
                       input logic rst);
        if (budget == 0) return;
        budget--;
        @(negedge clk);
        reset         = rst;
        opcode        = op;
        mem_resp      = resp;
        branch_enable = ben;
        exp_q.push_back(rst ? DEF : e);
        @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(DEF, r4(), r1(), r1(), 1'b1);
    endtask

    task automatic run_instr(input logic [3:0] op, input int wf,
                             input int wm, input logic ben,
                             input logic stray);
        cyc(V_F1, r4(), r1(), r1(), 1'b0);
        for (int i = 0; i <= wf; i++)
            cyc(V_RD, r4(), i == wf, r1(), 1'b0);
        cyc(V_F3, r4(), r1(), r1(), 1'b0);
        cyc(DEF, op, stray ? 1'b1 : r1(), r1(), 1'b0);
        case (op)
            OP_ADD: cyc(V_ALU, r4(), r1(), r1(), 1'b0);
            OP_AND: cyc(V_ALU | A_AND, r4(), r1(), r1(), 1'b0);
            OP_NOT: cyc(V_ALU | A_NOT, r4(), r1(), r1(), 1'b0);
            OP_BR: begin
                cyc(DEF, r4(), r1(), ben, 1'b0);
                if (ben) cyc(V_BRT, r4(), r1(), r1(), 1'b0);
            end
            OP_LDR: begin
                cyc(V_CALC, op, r1(), r1(), 1'b0);
                for (int i = 0; i <= wm; i++)
                    cyc(V_RD, r4(), i == wm, r1(), 1'b0);
                cyc(V_LDR2, r4(), r1(), r1(), 1'b0);
            end
            OP_STR: begin
                cyc(V_CALC, op, r1(), r1(), 1'b0);
                cyc(V_STR1, r4(), r1(), r1(), 1'b0);
                for (int i = 0; i <= wm; i++)
                    cyc(V_STR2, r4(), i == wm, r1(), 1'b0);
            end
            default: ;
        endcase
    endtask

    initial begin
        do_reset(2);
        // ADD with three wait cycles in fetch
        run_instr(OP_ADD, 3, 0, 1'b0, 1'b0);
        run_instr(OP_ADD, 0, 0, 1'b0, 1'b0);
        chk("add_len", last_len, 8);
        chk("add_reads", rd_last, 4);
        // Branch not taken, then taken
        run_instr(OP_BR, 0, 0, 1'b0, 1'b0);
        run_instr(OP_BR, 0, 0, 1'b1, 1'b0);
        chk("br_nt_len", last_len, 5);
        run_instr(OP_ADD, 0, 0, 1'b0, 1'b0);
        chk("br_t_len", last_len, 6);
        // LDR zero-wait
        run_instr(OP_LDR, 0, 0, 1'b0, 1'b0);
        run_instr(OP_AND, 0, 0, 1'b0, 1'b0);
        chk("ldr_len", last_len, 7);
        chk("ldr_reads", rd_last, 2);
        // STR with five wait cycles
        run_instr(OP_STR, 0, 5, 1'b0, 1'b0);
        run_instr(OP_NOT, 0, 0, 1'b0, 1'b0);
        chk("str_len", last_len, 12);
        chk("str_writes", wr_last, 6);
        chk("str_reads", rd_last, 1);
        // Reset in LDR1 while waiting
        cyc(V_F1, r4(), 1'b0, 1'b0, 1'b0);
        cyc(V_RD, r4(), 1'b1, 1'b0, 1'b0);
        cyc(V_F3, r4(), 1'b0, 1'b0, 1'b0);
        cyc(DEF, OP_LDR, 1'b0, 1'b0, 1'b0);
        cyc(V_CALC, OP_LDR, 1'b0, 1'b0, 1'b0);
        cyc(V_RD, r4(), 1'b0, 1'b0, 1'b0);
        cyc(DEF, r4(), 1'b0, 1'b0, 1'b1);
        // Illegal opcode with stray response in DECODE
        run_instr(4'hF, 0, 0, 1'b0, 1'b1);
        run_instr(OP_ADD, 0, 0, 1'b0, 1'b0);
        chk("nop_len", last_len, 4);
        // Reset from a partially executed store
        budget = 4;
        run_instr(OP_STR, 2, 0, 1'b0, 1'b0);
        budget = 1000000;
        do_reset(2);
        // Randomized instruction mix
        for (int n = 0; n < 300; n++) begin
            run_instr(r4(), $urandom_range(0, 3), $urandom_range(0, 3),
                      r1(), r1());
            if ($urandom_range(0, 15) == 0) begin
                budget = $urandom_range(1, 6);
                run_instr(OP_LDR, 1, 2, 1'b0, 1'b0);
                budget = 1000000;
                do_reset($urandom_range(1, 2));
            end
        end
        run_instr(OP_ADD, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        chk("trace_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
